// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 16x16 unsigned multiplier among four requesters,
// with a valid/ready result register and an accepted-result counter.

module multiplier_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = {16'b0, a} * {16'b0, b};
endmodule

module mult_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_id,
    output logic [31:0]          res_p,
    output logic                 busy,
    output logic [15:0]          op_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    logic [0:0]  state;
    logic [1:0]  last_winner;
    logic [1:0]  cur_id;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] mul_p;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;
    logic        load;
    logic        accept;

    multiplier_16bit u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    // Search order starts just past the previous winner and wraps.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last_winner + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign load   = (state == MUL) && (!res_valid || res_ready);
    assign accept = res_valid && res_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 2'd3;
            cur_id      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            gnt         <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_p       <= '0;
            op_count    <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a        <= req_a[{win, 4'b0000} +: 16];
                        op_b        <= req_b[{win, 4'b0000} +: 16];
                        cur_id      <= win;
                        last_winner <= win;
                        gnt[win]    <= 1'b1;
                        state       <= MUL;
                    end
                end
                default: begin
                    if (load) begin
                        state <= IDLE;
                    end
                end
            endcase

            // A load in the same edge as an accept replaces the result and keeps valid high.
            if (load) begin
                res_p     <= mul_p;
                res_id    <= cur_id;
                res_valid <= 1'b1;
            end else if (accept) begin
                res_valid <= 1'b0;
            end

            if (accept) begin
                op_count <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter with hand-computed expectations.

module tb_mult_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [31:0] res_p;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        #12;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        chk("rst_p", res_p, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(op_count), 32'h0);
        rst = 1'b0;

        // Single request 3*5
        req = 4'b0001; req_a = 64'd3; req_b = 64'd5;
        step();
        chk("s_gnt", 32'(gnt), 32'h1);
        chk("s_busy", 32'(busy), 32'h1);
        chk("s_valid0", 32'(res_valid), 32'h0);
        req = 4'b0000;
        step();
        chk("s_gnt_off", 32'(gnt), 32'h0);
        chk("s_valid", 32'(res_valid), 32'h1);
        chk("s_p", res_p, 32'd15);
        chk("s_id", 32'(res_id), 32'h0);
        chk("s_idle", 32'(busy), 32'h0);
        step();
        chk("s_valid_clr", 32'(res_valid), 32'h0);
        chk("s_cnt", 32'(op_count), 32'd1);

        // Max operands on requester 2
        req = 4'b0100; req_a = 64'h0000_FFFF_0000_0000; req_b = 64'h0000_FFFF_0000_0000;
        step();
        chk("m_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        step();
        chk("m_p", res_p, 32'hFFFE0001);
        chk("m_id", 32'(res_id), 32'd2);
        step();
        chk("m_cnt", 32'(op_count), 32'd2);

        // Round-robin from reset, requester i operands (i+1)*(i+2)
        rst = 1'b1; #2; rst = 1'b0;
        req = 4'b1111; req_a = 64'h0004_0003_0002_0001; req_b = 64'h0005_0004_0003_0002;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
            step();
            chk("rr_id", 32'(res_id), 32'(i % 4));
            chk("rr_p", res_p, 32'(((i % 4) + 1) * ((i % 4) + 2)));
        end
        req = 4'b0000;
        step();
        chk("rr_cnt", 32'(op_count), 32'd5);
        chk("rr_gnt_off", 32'(gnt), 32'h0);

        // Backpressure: last winner 0, so requester 1 wins first
        res_ready = 1'b0;
        req = 4'b0011; req_a = 64'h0000_0000_000A_0007; req_b = 64'h0000_0000_000B_0009;
        step();
        chk("bp_gnt1", 32'(gnt), 32'h2);
        req = 4'b0001;
        step();
        chk("bp_valid", 32'(res_valid), 32'h1);
        chk("bp_p1", res_p, 32'd110);
        step();
        chk("bp_gnt0", 32'(gnt), 32'h1);
        chk("bp_hold_p", res_p, 32'd110);
        req = 4'b0000;
        step();
        chk("bp_stall_busy", 32'(busy), 32'h1);
        chk("bp_stall_p", res_p, 32'd110);
        chk("bp_stall_id", 32'(res_id), 32'd1);
        step();
        chk("bp_stall_busy2", 32'(busy), 32'h1);
        chk("bp_stall_cnt", 32'(op_count), 32'd5);
        res_ready = 1'b1;
        step();
        chk("bp_p2", res_p, 32'd63);
        chk("bp_id2", 32'(res_id), 32'd0);
        chk("bp_valid2", 32'(res_valid), 32'h1);
        chk("bp_cnt1", 32'(op_count), 32'd6);
        chk("bp_idle", 32'(busy), 32'h0);
        step();
        chk("bp_valid_clr", 32'(res_valid), 32'h0);
        chk("bp_cnt2", 32'(op_count), 32'd7);

        // Reset during the grant cycle
        req = 4'b1000; req_a = 64'h0002_0000_0000_0000; req_b = 64'h0002_0000_0000_0000;
        step();
        chk("r_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        rst = 1'b1;
        #1;
        chk("r_gnt0", 32'(gnt), 32'h0);
        chk("r_busy", 32'(busy), 32'h0);
        chk("r_cnt", 32'(op_count), 32'h0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("r_valid", 32'(res_valid), 32'h0);
        chk("r_p", res_p, 32'h0);
        chk("r_gnt_after", 32'(gnt), 32'h0);
        req = 4'b1111;
        step();
        chk("r_next_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        chk("r_next_id", 32'(res_id), 32'd0);
        step();

        // op_count wrap via preload
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        #1;
        chk("w_pre", 32'(op_count), 32'hFFFF);
        req = 4'b0001; req_a = 64'd1; req_b = 64'd1;
        step();
        chk("w_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        chk("w_p", res_p, 32'd1);
        step();
        chk("w_cnt", 32'(op_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
